// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port block-RAM controller with CPU handshake; define MEM_CTRL_READBACK_EN to add write readback verification
module mem_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              verify_err,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, VERIFY, DONE} state_t;
  localparam int CW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic lat_end, start_rd, start_wr;
  assign start_rd = state == IDLE && mem_read && !mem_write;
  assign start_wr = state == IDLE && mem_write && !mem_read;
  assign lat_end = cnt == CW'(RD_LAT - 1);
  assign busy = state != IDLE;
  assign ack = state == DONE;
  // next-state: READ/VERIFY dwell for RD_LAT cycles, tracked by cnt
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   state_nxt = start_wr ? WRITE : start_rd ? READ : IDLE;
`ifdef MEM_CTRL_READBACK_EN
      WRITE:  state_nxt = VERIFY;
      VERIFY: state_nxt = lat_end ? DONE : VERIFY;
`else
      WRITE:  state_nxt = DONE;
`endif
      READ:   state_nxt = lat_end ? DONE : READ;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // state, latency counter, registered blockmem drive, read capture and sticky error
  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      state <= IDLE;
      cnt   <= '0;
      wea   <= 1'b0;
      addra <= '0;
      dina  <= '0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (state != IDLE && state_nxt == state) ? cnt + 1'b1 : '0;
      wea   <= start_wr;
      if (start_wr || start_rd) begin
        addra <= addr;
        dina  <= wdata;
      end
      if (state == IDLE && mem_read && mem_write) err <= 1'b1;
      if (state == READ && lat_end) rdata <= douta;
    end
  end
`ifdef MEM_CTRL_READBACK_EN
  // readback compare on the last VERIFY edge; sticky until reset
  always_ff @(posedge clka) begin
    if (!rsta_n) verify_err <= 1'b0;
    else if (state == VERIFY && lat_end && douta != dina) verify_err <= 1'b1;
  end
`else
  assign verify_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized self-checking bench for mem_ctrl against a word-level memory model
module tb_mem_ctrl;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 1;
`ifdef MEM_CTRL_READBACK_EN
  localparam int WR_ACK = 2 + RD_LAT;
`else
  localparam int WR_ACK = 2;
`endif
  logic clka = 1'b0;
  logic rsta_n, mem_read, mem_write, busy, ack, err, verify_err, wea;
  logic [ADDR_W-1:0] addr, addra;
  logic [DATA_W-1:0] wdata, rdata, dina, douta, raw;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] pipe0, pipe1, last_rd;
  logic force_zero, exp_err, exp_verr;
  int checks = 0;
  int failures = 0;

  always #5 clka = ~clka;

  mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clka(clka), .rsta_n(rsta_n), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .busy(busy), .ack(ack), .rdata(rdata), .err(err),
    .verify_err(verify_err), .wea(wea), .addra(addra), .dina(dina), .douta(douta)
  );

  // blockmem stand-in: synchronous write, RD_LAT-1 output register stages after the array read
  assign raw = mem[addra];
  always @(posedge clka) begin
    if (wea) mem[addra] <= dina;
    pipe0 <= raw;
    pipe1 <= pipe0;
  end
  assign douta = force_zero ? '0 : (RD_LAT == 1 ? raw : RD_LAT == 2 ? pipe0 : pipe1);

  task automatic txn(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit noisy);
    int e;
    logic [DATA_W-1:0] exp_rd;
    logic [ADDR_W+4:0] got, want;
    e = w ? WR_ACK : 1 + RD_LAT;
    exp_rd = w ? last_rd : ref_mem[a];
    @(negedge clka);
    mem_write = w;
    mem_read = !w;
    addr = a;
    wdata = d;
    for (int c = 1; c <= e + 1; c++) begin
      @(negedge clka);
      got = {busy, ack, wea, err, verify_err, addra};
      want = {c <= e, c == e, w && c == 1, exp_err, exp_verr, a};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL %s a=%h cyc=%0d {busy,ack,wea,err,verr,addra}: got %h want %h", w ? "write" : "read", a, c, got, want);
      end
      if (c == e) begin
        checks++;
        if (rdata !== exp_rd) begin
          failures++;
          $display("FAIL %s_rdata a=%h: got %h want %h", w ? "write" : "read", a, rdata, exp_rd);
        end
      end
      if (w && c == 1) begin
        checks++;
        if (dina !== d) begin
          failures++;
          $display("FAIL write_dina a=%h: got %h want %h", a, dina, d);
        end
      end
      if (noisy && c < e) begin
        mem_read = 1'($urandom);
        mem_write = 1'($urandom);
        addr = ADDR_W'($urandom);
        wdata = DATA_W'($urandom);
      end else begin
        mem_read = 1'b0;
        mem_write = 1'b0;
      end
    end
    if (w) ref_mem[a] = d;
    else last_rd = exp_rd;
  endtask

  task automatic test_reset();
    mem_read = 1'b0;
    mem_write = 1'b0;
    rsta_n = 1'b0;
    repeat (2) @(negedge clka);
    checks++;
    if ({busy, ack, wea, err, verify_err, addra, dina, rdata} !== '0) begin
      failures++;
      $display("FAIL reset_state: busy=%b ack=%b wea=%b err=%b verr=%b addra=%h dina=%h rdata=%h want all 0", busy, ack, wea, err, verify_err, addra, dina, rdata);
    end
    rsta_n = 1'b1;
    exp_err = 1'b0;
    exp_verr = 1'b0;
    last_rd = '0;
    @(negedge clka);
    checks++;
    if ({busy, ack, wea, err, verify_err} !== 5'b0) begin
      failures++;
      $display("FAIL post_reset_idle: got %b want 00000", {busy, ack, wea, err, verify_err});
    end
  endtask

  task automatic test_write_read();
    txn(1'b1, 12'h0A5, 16'h1234, 1'b0);
    txn(1'b0, 12'h0A5, 16'h0000, 1'b0);
  endtask

  task automatic test_boundary();
    txn(1'b1, 12'h000, 16'hA001, 1'b0);
    txn(1'b1, 12'hFFF, 16'h5FFE, 1'b0);
    txn(1'b0, 12'hFFF, 16'h0000, 1'b0);
    txn(1'b0, 12'h000, 16'h0000, 1'b0);
  endtask

  task automatic test_reset_abort();
    @(negedge clka);
    mem_write = 1'b1;
    addr = 12'h123;
    wdata = 16'hDEAD;
    rsta_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clka);
      checks++;
      if ({busy, wea, ack} !== 3'b0) begin
        failures++;
        $display("FAIL abort_before_write cyc=%0d {busy,wea,ack}: got %b want 000", c, {busy, wea, ack});
      end
      rsta_n = 1'b1;
      mem_write = 1'b0;
    end
    last_rd = '0;
    txn(1'b0, 12'h123, 16'h0000, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clka);
    mem_write = 1'b1;
    addr = 12'hFFF;
    wdata = 16'hBEEF;
    @(negedge clka);
    mem_write = 1'b0;
    checks++;
    if ({busy, wea} !== 2'b11) begin
      failures++;
      $display("FAIL mid_write_cycle {busy,wea}: got %b want 11", {busy, wea});
    end
    rsta_n = 1'b0;
    @(negedge clka);
    checks++;
    if ({busy, ack, wea, addra, dina, rdata} !== '0) begin
      failures++;
      $display("FAIL reset_in_write: busy=%b ack=%b wea=%b addra=%h dina=%h rdata=%h want all 0", busy, ack, wea, addra, dina, rdata);
    end
    rsta_n = 1'b1;
    last_rd = '0;
    exp_err = 1'b0;
    exp_verr = 1'b0;
    // wea was already high at the reset edge, so the blockmem took the word on that edge
    ref_mem[12'hFFF] = 16'hBEEF;
    txn(1'b0, 12'hFFF, 16'h0000, 1'b0);
  endtask

  task automatic test_back_to_back();
    txn(1'b0, 12'h7FF, 16'h0000, 1'b1);
    for (int i = 0; i < 300; i++)
      txn(1'($urandom), ADDR_W'($urandom_range(0, 63) << 6 | $urandom_range(0, 63)), DATA_W'($urandom), 1'($urandom));
  endtask

  task automatic test_sweep();
    for (int i = 0; i < (1 << ADDR_W); i++) txn(1'b1, ADDR_W'(i), DATA_W'(i), 1'b0);
    for (int i = 0; i < (1 << ADDR_W); i++) txn(1'b0, ADDR_W'(i), 16'h0000, 1'b0);
  endtask

`ifdef MEM_CTRL_READBACK_EN
  task automatic test_verify();
    int acks = 0;
    @(negedge clka);
    mem_write = 1'b1;
    addr = 12'h2C3;
    wdata = 16'h5A5A;
    @(negedge clka);
    mem_write = 1'b0;
    force_zero = 1'b1;
    for (int c = 2; c <= WR_ACK + 1; c++) begin
      @(negedge clka);
      if (ack) acks++;
    end
    force_zero = 1'b0;
    ref_mem[12'h2C3] = 16'h5A5A;
    exp_verr = 1'b1;
    checks++;
    if (acks != 1) begin
      failures++;
      $display("FAIL verify_ack_count: got %0d want 1", acks);
    end
    checks++;
    if (verify_err !== 1'b1) begin
      failures++;
      $display("FAIL verify_err_set: got %b want 1", verify_err);
    end
    txn(1'b0, 12'h2C3, 16'h0000, 1'b0);
  endtask
`endif

  task automatic test_error();
    logic [ADDR_W-1:0] held;
    held = addra;
    @(negedge clka);
    mem_read = 1'b1;
    mem_write = 1'b1;
    addr = ~held;
    for (int c = 0; c < 3; c++) begin
      @(negedge clka);
      if (c == 1) begin
        mem_read = 1'b0;
        mem_write = 1'b0;
      end
      checks++;
      if ({busy, ack, wea, err, addra} !== {4'b0001, held}) begin
        failures++;
        $display("FAIL dual_request cyc=%0d {busy,ack,wea,err,addra}: got %h want %h", c, {busy, ack, wea, err, addra}, {4'b0001, held});
      end
    end
    exp_err = 1'b1;
    txn(1'b1, 12'h3C3, 16'h0F0F, 1'b0);
    txn(1'b0, 12'h3C3, 16'h0000, 1'b0);
  endtask

  initial begin
    force_zero = 1'b0;
    addr = '0;
    wdata = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_write_read();
    test_boundary();
    test_reset_abort();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
`ifdef MEM_CTRL_READBACK_EN
    test_verify();
`endif
    test_error();
    test_reset();
    txn(1'b0, 12'h0A5, 16'h0000, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
